// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 fetch-redirect logic.
//   OP_JAL / OP_JALR / OP_BRANCH : instr[6:2] opcode constants
//   state_e                      : redirect FSM state encoding
//   BOOT_ADDR_DEFAULT            : default reset PC
package msrv32_pkg;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/msrv32_target_gen.sv
// Combinational control-flow target generator.
//   opcode_in             : instr[6:2]
//   pc_in, imm_in, rs1_in : operands for the target add
//   target_out            : JALR -> (rs1+imm) with bit 0 cleared, otherwise pc+imm
//   target_bit1_out       : target is not word aligned (bit 1 set)
module msrv32_target_gen
    import msrv32_pkg::*;
(
    input  logic [4:0]  opcode_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    output logic [31:0] target_out,
    output logic        target_bit1_out
);

    logic [31:0] pc_rel_sum;
    logic [31:0] rs1_rel_sum;

    assign pc_rel_sum  = pc_in + imm_in;
    assign rs1_rel_sum = rs1_in + imm_in;

    // Anything other than JALR (including opcodes the branch unit never
    // flags as taken) uses the PC-relative target.
    always_comb begin
        target_out = pc_rel_sum;
        if (opcode_in == OP_JALR) begin
            target_out = {rs1_rel_sum[31:1], 1'b0};
        end
    end

    assign target_bit1_out = target_out[1];

endmodule

// File: rtl/msrv32_pc_redirect_ctrl.sv
// Fetch PC sequencer: picks the next fetch address each cycle (sequential,
// branch/JAL target, JALR target or trap vector) and raises a one-cycle
// flush of the wrong-path instruction after every redirect or trap.
//
// Ports:
//   ms_riscv32_mp_clk_in   : clock, all state on rising edge
//   ms_riscv32_mp_rst_in   : synchronous active-high reset
//   branch_taken_in        : taken decision from the branch unit
//   opcode_in              : instr[6:2] of the decode-stage instruction
//   pc_in, imm_in, rs1_in  : target operands
//   trap_taken_in          : trap accepted, load trap_addr_in
//   trap_addr_in           : trap vector / mepc
//   stall_in               : freeze PC and FSM
//   pc_out                 : registered fetch PC
//   iaddr_out              : next PC (combinational) to instruction memory
//   flush_out              : decode-stage instruction is invalid
//   misaligned_instr_out   : taken target has bit 1 set, redirect dropped
//
// Optional build macro MSRV32_BRANCH_STATS_EN adds br_taken_cnt_out and
// br_total_cnt_out conditional-branch counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal fetch, redirects accepted
// ST_FLUSH | instruction in decode is wrong-path; flush_out=1, branches ignored
module msrv32_pc_redirect_ctrl
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        stall_in,
`ifdef MSRV32_BRANCH_STATS_EN
    output logic [31:0] br_taken_cnt_out,
    output logic [31:0] br_total_cnt_out,
`endif
    output logic [31:0] pc_out,
    output logic [31:0] iaddr_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] target;
    logic        target_bit1;
    logic        in_run;
    logic        redirect;

    msrv32_target_gen u_target_gen (
        .opcode_in       (opcode_in),
        .pc_in           (pc_in),
        .imm_in          (imm_in),
        .rs1_in          (rs1_in),
        .target_out      (target),
        .target_bit1_out (target_bit1)
    );

    assign in_run               = (state_q == ST_RUN);
    assign misaligned_instr_out = branch_taken_in & in_run & target_bit1;
    assign redirect             = branch_taken_in & in_run & ~target_bit1;

    always_comb begin
        iaddr_out = pc_q + 32'd4;
        state_d   = ST_RUN;
        if (ms_riscv32_mp_rst_in) begin
            iaddr_out = BOOT_ADDR;
            state_d   = ST_RUN;
        end else if (trap_taken_in) begin
            // Trap overrides a stall: the vector must be captured now.
            iaddr_out = trap_addr_in;
            state_d   = ST_FLUSH;
        end else if (stall_in) begin
            iaddr_out = pc_q;
            state_d   = state_q;
        end else if (redirect) begin
            iaddr_out = target;
            state_d   = ST_FLUSH;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        pc_q    <= iaddr_out;
        state_q <= state_d;
    end

    assign pc_out    = pc_q;
    assign flush_out = (state_q == ST_FLUSH);

`ifdef MSRV32_BRANCH_STATS_EN
    logic [31:0] br_taken_cnt_q;
    logic [31:0] br_total_cnt_q;
    logic        count_en;

    assign count_en = in_run & ~stall_in & (opcode_in == OP_BRANCH);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            br_taken_cnt_q <= 32'd0;
            br_total_cnt_q <= 32'd0;
        end else if (count_en) begin
            br_total_cnt_q <= br_total_cnt_q + 32'd1;
            if (redirect) begin
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
            end
        end
    end

    assign br_taken_cnt_out = br_taken_cnt_q;
    assign br_total_cnt_out = br_total_cnt_q;
`endif

endmodule
